// File: rtl/mask_packer.sv
// Packs a frame of N-bit mask pixels into W-bit words, LSB-first, one line per word group,
// and presents them through a small show-ahead FIFO on a valid/ready interface.
module mask_packer #(
    parameter int unsigned N     = 1,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:0]  width,
    input  logic [15:0]  height,
    input  logic         start,
    input  logic         in_write,
    input  logic [N-1:0] in_pixel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int unsigned P  = W / N;
    localparam int unsigned SW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e         state_q, state_d;
    logic [15:0]    width_q, width_d, height_q, height_d;
    logic [15:0]    col_q, col_d, row_q, row_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [W-1:0]   pack_q, pack_d;
    logic           overflow_q, overflow_d;
    logic           done_q, done_d;

    logic [W:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;

    logic           push, push_last, push_ok, pop, full, empty;
    logic           line_end, word_end, frame_end;
    logic [W-1:0]   pix_word, word;
    int unsigned    shamt;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign pop       = !empty && out_ready;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign push_ok   = push && (!full || pop);

    assign line_end  = (col_q == width_q - 16'd1);
    assign word_end  = (slot_q == SW'(P - 1)) || line_end;
    assign frame_end = line_end && (row_q == height_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        col_d      = col_q;
        row_d      = row_q;
        slot_d     = slot_q;
        pack_d     = pack_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        shamt      = N * 32'(slot_q);
        pix_word   = W'(in_pixel) << shamt;
        word       = pack_q | pix_word;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    width_d    = width;
                    height_d   = height;
                    col_d      = '0;
                    row_d      = '0;
                    slot_d     = '0;
                    pack_d     = '0;
                    overflow_d = 1'b0;
                    state_d    = (width == 16'd0 || height == 16'd0) ? StFlush : StRun;
                end
            end
            StRun: begin
                if (in_write) begin
                    if (word_end) begin
                        push   = 1'b1;
                        slot_d = '0;
                        pack_d = '0;
                    end else begin
                        slot_d = slot_q + SW'(1);
                        pack_d = word;
                    end
                    if (line_end) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (frame_end) begin
                        push_last = 1'b1;
                        state_d   = StFlush;
                    end
                end
            end
            StFlush: begin
                if (empty) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push && !push_ok) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            slot_q     <= '0;
            pack_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_last, word};
    end

    // Gate the head so an empty or freshly reset FIFO shows all-zero outputs.
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q][W-1:0];
    assign out_last  = empty ? 1'b0 : mem_q[rd_ptr_q][W];
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mask_packer.sv
// Randomised bench for mask_packer: a frame-level reference model (pixel arrays and a
// bounded word queue) predicts every output on every cycle.
module tb_mask_packer;

    localparam int N     = 1;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int P     = W / N;

    logic         clock = 1'b0;
    logic         reset;
    logic [15:0]  width, height;
    logic         start, in_write, out_ready;
    logic [N-1:0] in_pixel;
    logic         out_valid, out_last, busy, done, overflow;
    logic [W-1:0] out_data;

    mask_packer #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .width     (width),
        .height    (height),
        .start     (start),
        .in_write  (in_write),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 accepting pixels, 2 draining.
    int           m_phase = 0;
    int           m_w, m_h, m_col, m_row;
    logic         m_ovf  = 1'b0;
    logic         m_done = 1'b0;
    logic [W:0]   mq[$];
    logic [N-1:0] line_pix[int];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [W:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check("out_valid", out_valid, mq.size() > 0);
        check("out_data", out_data, head[W-1:0]);
        check("out_last", out_last, head[W]);
        check("overflow", overflow, m_ovf);
        check("busy", busy, m_phase != 0);
        check("done", done, m_done);
    endtask

    function automatic bit completes_word();
        return ((m_col + 1) % P == 0) || (m_col == m_w - 1);
    endfunction

    // Advance the model by one edge using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int         sz;
        bit         pop, pushw, nxt_done;
        logic [W:0] word;
        sz       = mq.size();
        pop      = out_ready && (sz > 0);
        pushw    = 1'b0;
        nxt_done = 1'b0;
        word     = '0;
        case (m_phase)
            0: if (start) begin
                m_w = int'(width);
                m_h = int'(height);
                m_col = 0;
                m_row = 0;
                m_ovf = 1'b0;
                line_pix.delete();
                m_phase = (width == 0 || height == 0) ? 2 : 1;
            end
            1: if (in_write) begin
                line_pix[m_col] = in_pixel;
                if (completes_word()) begin
                    for (int c = m_col - (m_col % P); c <= m_col; c++)
                        word[(c % P) * N +: N] = line_pix[c];
                    word[W] = (m_col == m_w - 1) && (m_row == m_h - 1);
                    pushw = 1'b1;
                    if (word[W]) m_phase = 2;
                end
                if (m_col == m_w - 1) begin
                    m_col = 0;
                    m_row++;
                    line_pix.delete();
                end else begin
                    m_col++;
                end
            end
            default: if (sz == 0) begin
                nxt_done = 1'b1;
                m_phase = 0;
            end
        endcase
        if (pop) void'(mq.pop_front());
        if (pushw) begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(word);
        end
        m_done = nxt_done;
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    // rmode: 0 ready always, 1 random, 2 stalled then released in drain, 3 pop only on full+push.
    // pmode: 0 random pixels, 1 all ones, 2 the 8-pixel pattern 1,0,1,1,0,0,0,1.
    task automatic run_frame(input int w, input int h, input int rmode, input int pmode,
                             input int wr_pct);
        int         budget;
        int         hold;
        logic [7:0] pat;
        pat       = 8'h8D;
        width     = 16'(w);
        height    = 16'(h);
        start     = 1'b1;
        in_write  = 1'b0;
        out_ready = (rmode == 0);
        tick();
        start  = 1'b0;
        budget = 0;
        hold   = 0;
        while (m_phase != 0 && budget < 5000) begin
            budget++;
            in_write = ($urandom_range(0, 99) < wr_pct);
            case (pmode)
                0:       in_pixel = N'($urandom);
                1:       in_pixel = '1;
                default: in_pixel = N'(pat[m_col % 8]);
            endcase
            start = (m_phase == 1) && ($urandom_range(0, 49) == 0);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 70);
                2: begin
                    out_ready = (m_phase == 2) && (hold >= 5);
                    if (m_phase == 2) hold++;
                end
                default: out_ready = (m_phase == 2) ||
                    (mq.size() == DEPTH && in_write && m_phase == 1 && completes_word());
            endcase
            tick();
        end
        start    = 1'b0;
        in_write = 1'b0;
        check("frame_ends_idle", busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        width     = '0;
        height    = '0;
        start     = 1'b0;
        in_write  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs();
        reset = 1'b0;

        // in_write while idle must be ignored.
        in_write = 1'b1;
        in_pixel = '1;
        repeat (3) tick();
        in_write = 1'b0;

        run_frame(8, 2, 0, 2, 100);
        run_frame(40, 1, 0, 1, 100);
        run_frame(32, 6, 2, 1, 100);
        run_frame(0, 5, 0, 0, 50);

        // Reset in the middle of a line aborts the frame silently.
        width     = 16'd16;
        height    = 16'd1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_write = 1'b1;
            in_pixel = N'($urandom);
            tick();
        end
        in_write = 1'b0;
        reset    = 1'b1;
        #1;
        mq.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        tick();
        run_frame(16, 1, 0, 0, 100);

        run_frame(32, 8, 3, 0, 100);

        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(1, 70), $urandom_range(1, 4), 1, 0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mask_packer.md
Name: mask_packer

Overview:
- Terminal consumer of the morphological pixel-stream interface: a write strobe plus an N-bit pixel per accepted beat, with no backpressure.
- Packs the binary/N-bit mask pixels of one frame into W-bit words, LSB-first. Each line starts on a word boundary.
- Presents the words on a valid/ready interface through a small show-ahead FIFO, for a memory-write master.
- Tracks column/row against the programmed frame size, flags the frame's last word and reports overflow when the downstream stalls too long.

Parameters:
- N, 1, bits per pixel (matches the upstream filter stage).
- W, 32, output word width; must be a multiple of N.
- DEPTH, 4, output FIFO depth in words, power of two, ≥2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- width  in  16  pixels per line, sampled on start.
- height  in  16  lines per frame, sampled on start.
- start  in  1  one-cycle pulse that arms a frame.
- in_write  in  1  pixel strobe from the upstream stage.
- in_pixel  in  N  pixel data, valid when in_write=1.
- out_valid  out  1  FIFO head word available.
- out_data  out  W  packed word.
- out_last  out  1  head word is the last word of the frame.
- out_ready  in  1  downstream accepts the head word when out_valid=1.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at frame completion.
- overflow  out  1  sticky: a word was dropped on a full FIFO.

Behaviour:
- Reset: all outputs 0. State IDLE. Column, row, slot and pack register cleared. FIFO emptied. Reset mid-frame aborts the frame with no done pulse.
- Derived values: P = W/N pixels per word; words per line = ceil(width/P). Pixel at slot s occupies out_data[s*N +: N]. Unfilled slots are 0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_write is ignored.
  - start latches width and height, clears col/row/slot/pack and overflow, then goes to RUN.
  - If the latched width=0 or height=0, go straight to FLUSH; no words are produced.
- RUN, on each in_write:
  - Write the pixel into the slot, then increment slot.
  - A push to the FIFO happens when slot=P-1 or col=width-1; then slot returns to 0 and pack is cleared.
  - On col=width-1: col returns to 0 and row increments.
  - The pixel with col=width-1 and row=height-1 pushes its word with last=1, and the state goes to FLUSH.
  - start in RUN is ignored.
- Push timing: the word is in the FIFO after the edge that accepted the completing in_write. out_valid is high in the next cycle (latency 1).
- FIFO:
  - Show-ahead: out_data and out_last always reflect the head word.
  - A pop occurs when out_valid and out_ready are both 1.
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - A push while full with no pop drops that word and sets overflow. Counters keep advancing. If the dropped word carried last=1, the state still goes to FLUSH.
- FLUSH: when the FIFO is empty, pulse done for one cycle and go to IDLE. busy falls in the same cycle done pulses.
- in_write in FLUSH is ignored; the upstream is expected to be quiescent.
- Counters are 16-bit; width and height up to 65535 are supported.

Test Plan:
- N=1, W=32, width=8, height=2, out_ready=1, pixels 1,0,1,1,0,0,0,1 on each line → 2 words of 0x0000008D, out_last only on the 2nd. done pulses once; busy high from start through done.
- width=40, height=1, all pixels 1 → words 0xFFFFFFFF then 0x000000FF (last=1). First out_valid appears 1 cycle after the 32nd in_write.
- out_ready=0, DEPTH=4, width=32, height=6, all pixels 1 → 4 words held, 2 dropped, overflow=1 and stays 1. The state stays in FLUSH until 4 pops; then done. The next start clears overflow.
- width=0, height=5, start → no out_valid; done pulses within 2 cycles of start; busy returns to 0.
- Reset asserted after 10 of 16 pixels (width=16, height=1) → all outputs 0 immediately, no done. A subsequent full frame produces exactly 1 word with correct data.
- FIFO full with push and pop in the same cycle (out_ready=1 while full) → no drop, overflow stays 0, word order preserved.
